// File: rtl/i2c_master_mb.sv
// Multi-byte I2C master: START, address byte, len data bytes (write or read), STOP.
// Quarter-period timing with clock-stretch support on the open-drain SCL line.
module i2c_master_mb #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic             read_write,
    input  logic [6:0]       addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             ready_out,
    output logic             ack_err,
    inout  wire              i2c_scl_inout,
    inout  wire              i2c_sda_inout
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q;
    logic [1:0]        qtr_q;
    logic [2:0]        bit_q;
    logic [LEN_W-1:0]  rem_q;
    logic [7:0]        tx_q, rx_q, rd_data_q;
    logic              rw_q, nack_q, ack_err_q, rd_valid_q;
    logic              scl_low, sda_low, scl_in, sda_in;
    logic              stall, qtick, bit_end, sample, last_bit;

    assign i2c_scl_inout = scl_low ? 1'b0 : 1'bz;
    assign i2c_sda_inout = sda_low ? 1'b0 : 1'bz;
    assign scl_in        = i2c_scl_inout;
    assign sda_in        = i2c_sda_inout;

    // A slave holding SCL low while we release it freezes the quarter timer.
    assign stall    = (state_q != IDLE) && !scl_low && !scl_in;
    assign qtick    = (state_q != IDLE) && !stall && (div_q == DW'(CLK_DIV - 1));
    assign bit_end  = qtick && (qtr_q == 2'd3);
    assign sample   = qtick && (qtr_q == 2'd1);
    assign last_bit = (bit_q == 3'd0);

    assign ready_out = (state_q == IDLE);
    assign ack_err   = ack_err_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = START;
            START:    if (bit_end) state_d = ADDR;
            ADDR:     if (bit_end && last_bit) state_d = ADDR_ACK;
            ADDR_ACK: if (bit_end) begin
                          if (nack_q || rem_q == '0) state_d = STOP;
                          else if (rw_q)             state_d = READ;
                          else                       state_d = WRITE;
                      end
            WRITE:    if (bit_end && last_bit) state_d = WR_ACK;
            WR_ACK:   if (bit_end) state_d = (nack_q || rem_q == LEN_W'(1)) ? STOP : WRITE;
            READ:     if (bit_end && last_bit) state_d = RD_ACK;
            RD_ACK:   if (bit_end) state_d = (rem_q == LEN_W'(1)) ? STOP : READ;
            STOP:     if (bit_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_low  = 1'b0;
        sda_low  = 1'b0;
        wr_ready = 1'b0;
        case (state_q)
            START: begin
                sda_low = 1'b1;
                scl_low = qtr_q[1];
            end
            ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK: begin
                scl_low = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                if (state_q == ADDR) sda_low = !tx_q[7];
                if (state_q == WRITE) begin
                    // First cycle of a byte: the new byte is only captured at this edge.
                    wr_ready = (bit_q == 3'd7) && (qtr_q == 2'd0) && (div_q == '0);
                    sda_low  = wr_ready ? !wr_data[7] : !tx_q[7];
                end
                if (state_q == RD_ACK) sda_low = (rem_q != LEN_W'(1));
            end
            STOP: begin
                scl_low = (qtr_q == 2'd0);
                sda_low = (qtr_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            rem_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                div_q <= '0;
                qtr_q <= '0;
                if (start) begin
                    tx_q      <= {addr, read_write};
                    rw_q      <= read_write;
                    rem_q     <= len;
                    bit_q     <= 3'd7;
                    nack_q    <= 1'b0;
                    ack_err_q <= 1'b0;
                end
            end else begin
                if (!stall) div_q <= qtick ? '0 : div_q + DW'(1);
                if (qtick)  qtr_q <= qtr_q + 2'd1;
                if (wr_ready) tx_q <= wr_data;
                if (bit_end && (state_q == ADDR || state_q == WRITE || state_q == READ))
                    bit_q <= bit_q - 3'd1;
                if (bit_end && (state_q == ADDR || state_q == WRITE))
                    tx_q <= {tx_q[6:0], 1'b0};
                if (bit_end && (state_q == WR_ACK || state_q == RD_ACK))
                    rem_q <= rem_q - LEN_W'(1);
                if (sample) begin
                    case (state_q)
                        ADDR_ACK, WR_ACK: begin
                            nack_q <= sda_in;
                            if (sda_in) ack_err_q <= 1'b1;
                        end
                        READ: begin
                            rx_q <= {rx_q[6:0], sda_in};
                            if (last_bit) begin
                                rd_data_q  <= {rx_q[6:0], sda_in};
                                rd_valid_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_mb.sv
// Directed bench for i2c_master_mb with a bus monitor and a simple ACKing/stretching slave.
module tb_i2c_master_mb;
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       start = 1'b0;
    logic       read_write = 1'b0;
    logic [6:0] addr = '0;
    logic [3:0] len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, rd_valid, ready_out, ack_err;
    logic [7:0] rd_data;
    wire        scl, sda;

    logic       s_scl_low = 1'b0, s_sda_low = 1'b0;
    logic       s_read = 1'b0, s_addr_ack = 1'b1;
    int         s_nbytes = 0, s_stretch_idx = -1;
    logic [7:0] rd_bytes [0:1];

    pullup (scl);
    pullup (sda);
    assign scl = s_scl_low ? 1'b0 : 1'bz;
    assign sda = s_sda_low ? 1'b0 : 1'bz;

    i2c_master_mb #(.CLK_DIV(4), .LEN_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .read_write(read_write),
        .addr(addr), .len(len), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .ready_out(ready_out),
        .ack_err(ack_err), .i2c_scl_inout(scl), .i2c_sda_inout(sda)
    );

    always #5 clk_in = ~clk_in;

    // Bus monitor + slave
    logic       pscl = 1'b1, psda = 1'b1;
    logic       bits [0:255];
    int         nbits = 0, stop_cnt = 0, scnt = 0, wr_cnt = 0, rd_cnt = 0;
    logic [7:0] rd_log [0:63];

    function automatic logic slave_drive(input int idx);
        int j, p;
        if (idx == 8) return s_addr_ack;
        if (idx < 9) return 1'b0;
        j = (idx - 9) / 9;
        p = (idx - 9) % 9;
        if (j >= s_nbytes) return 1'b0;
        if (s_read) return (p < 8) ? !rd_bytes[j][7-p] : 1'b0;
        return (p == 8);
    endfunction

    always @(posedge clk_in) begin
        pscl <= scl;
        psda <= sda;
        if (pscl && scl && psda && !sda) nbits <= 0;
        else if (!pscl && scl && nbits < 256) begin
            bits[nbits] <= sda;
            nbits       <= nbits + 1;
        end
        if (pscl && scl && !psda && sda) stop_cnt <= stop_cnt + 1;
        if (scnt != 0) begin
            scnt <= scnt - 1;
            if (scnt == 1) s_scl_low <= 1'b0;
        end
        if (pscl && !scl) begin
            s_sda_low <= slave_drive(nbits);
            if (nbits == s_stretch_idx) begin
                s_scl_low <= 1'b1;
                scnt      <= 17;
            end
        end
        if (wr_ready) wr_cnt <= wr_cnt + 1;
        if (rd_valid && rd_cnt < 64) begin
            rd_log[rd_cnt] <= rd_data;
            rd_cnt         <= rd_cnt + 1;
        end
    end

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int s);
        logic [7:0] b = '0;
        for (int k = 0; k < 8; k++) b = {b[6:0], bits[s+k]};
        return b;
    endfunction

    // Called just after a posedge; the next posedge is the accept edge.
    task automatic start_xfer(input logic rw, input logic [6:0] a, input logic [3:0] n);
        read_write = rw; addr = a; len = n; start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        chk("ready_drop", {31'd0, ready_out}, 32'd0);
    endtask

    task automatic wait_ready(input int already, output int cyc);
        cyc = already;
        do begin
            @(posedge clk_in); #1;
            cyc++;
        end while (!ready_out && cyc < 5000);
    endtask

    int cyc, w0, r0, s0;

    initial begin
        rd_bytes[0] = 8'h96;
        rd_bytes[1] = 8'h3C;

        // Reset then idle
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        chk("rst_ready",  {31'd0, ready_out}, 32'd1);
        chk("rst_scl",    {31'd0, scl},       32'd1);
        chk("rst_sda",    {31'd0, sda},       32'd1);
        chk("rst_ackerr", {31'd0, ack_err},   32'd0);
        chk("rst_wrrdy",  {31'd0, wr_ready},  32'd0);
        chk("rst_rdvld",  {31'd0, rd_valid},  32'd0);
        chk("rst_rddata", {24'd0, rd_data},   32'd0);

        // Write len=1, 0xFF; a start while busy must be ignored
        s_read = 1'b0; s_addr_ack = 1'b1; s_nbytes = 1; wr_data = 8'hFF;
        w0 = wr_cnt; s0 = stop_cnt;
        start_xfer(1'b0, 7'h55, 4'd1);
        repeat (49) @(posedge clk_in);
        #1 addr = 7'h12; read_write = 1'b1; start = 1'b1;
        @(posedge clk_in); #1 start = 1'b0;
        wait_ready(50, cyc);
        chk("wr_latency", cyc, 32'd320);
        chk("wr_addr",    {24'd0, get_byte(0)}, 32'hAA);
        chk("wr_data",    {24'd0, get_byte(9)}, 32'hFF);
        chk("wr_pulses",  wr_cnt - w0, 32'd1);
        chk("wr_ackerr",  {31'd0, ack_err}, 32'd0);
        chk("wr_stop",    stop_cnt - s0, 32'd1);

        // Read len=2: 0x96, 0x3C
        s_read = 1'b1; s_nbytes = 2; r0 = rd_cnt;
        start_xfer(1'b1, 7'h55, 4'd2);
        wait_ready(0, cyc);
        chk("rd_latency", cyc, 32'd464);
        chk("rd_addr",    {24'd0, get_byte(0)}, 32'hAB);
        chk("rd_pulses",  rd_cnt - r0, 32'd2);
        chk("rd_byte0",   {24'd0, rd_log[r0]},   32'h96);
        chk("rd_byte1",   {24'd0, rd_log[r0+1]}, 32'h3C);
        chk("rd_mack",    {31'd0, bits[17]}, 32'd0);
        chk("rd_mnack",   {31'd0, bits[26]}, 32'd1);
        chk("rd_ackerr",  {31'd0, ack_err}, 32'd0);

        // Address NACK, len=3 write
        s_read = 1'b0; s_addr_ack = 1'b0; s_nbytes = 3;
        w0 = wr_cnt; s0 = stop_cnt;
        start_xfer(1'b0, 7'h55, 4'd3);
        wait_ready(0, cyc);
        chk("nack_latency", cyc, 32'd176);
        chk("nack_ackerr",  {31'd0, ack_err}, 32'd1);
        chk("nack_pulses",  wr_cnt - w0, 32'd0);
        chk("nack_stop",    stop_cnt - s0, 32'd1);

        // Clock stretch of 10 cycles on address bit 3
        s_addr_ack = 1'b1; s_nbytes = 1; s_stretch_idx = 4; w0 = wr_cnt;
        start_xfer(1'b0, 7'h55, 4'd1);
        wait_ready(0, cyc);
        s_stretch_idx = -1;
        chk("st_latency", cyc, 32'd330);
        chk("st_addr",    {24'd0, get_byte(0)}, 32'hAA);
        chk("st_data",    {24'd0, get_byte(9)}, 32'hFF);
        chk("st_pulses",  wr_cnt - w0, 32'd1);
        chk("st_ackerr",  {31'd0, ack_err}, 32'd0);

        // Maximum length: 15 bytes, no counter wrap
        s_nbytes = 15; wr_data = 8'h5A; w0 = wr_cnt;
        start_xfer(1'b0, 7'h31, 4'd15);
        wait_ready(0, cyc);
        chk("max_latency", cyc, 32'd2336);
        chk("max_pulses",  wr_cnt - w0, 32'd15);
        chk("max_addr",    {24'd0, get_byte(0)}, 32'h62);
        chk("max_last",    {24'd0, get_byte(9 + 9*14)}, 32'h5A);

        // Reset in the middle of the first data byte, then immediate probe
        s_nbytes = 2; wr_data = 8'hC3;
        start_xfer(1'b0, 7'h55, 4'd2);
        repeat (223) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("mrst_scl",    {31'd0, scl},       32'd1);
        chk("mrst_sda",    {31'd0, sda},       32'd1);
        chk("mrst_ready",  {31'd0, ready_out}, 32'd1);
        chk("mrst_rddata", {24'd0, rd_data},   32'd0);
        rst_in = 1'b0;
        s_nbytes = 0;
        start_xfer(1'b0, 7'h2A, 4'd0);
        wait_ready(0, cyc);
        chk("probe_latency", cyc, 32'd176);
        chk("probe_addr",    {24'd0, get_byte(0)}, 32'h54);
        chk("probe_ackerr",  {31'd0, ack_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
